// File: rtl/dot_product_acc_pkg.sv
// Shared definitions for the dot-product accumulator: state encoding and width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dot_product_acc_pkg;

   // The FSM has two states: collecting terms, or holding a finished sum.
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Accumulator width: the full product width plus guard bits.
   function automatic int acc_width(input int n, input int g);
      return 2 * n + g;
   endfunction

   // term_count must be able to represent MAX_TERMS itself.
   function automatic int count_width(input int max_terms);
      return $clog2(max_terms + 1);
   endfunction

endpackage

// File: rtl/dot_product_acc_acc_adder.sv
// W-bit ripple-carry adder with carry-out, one full-adder cell per bit.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (W-bit addends), sum (W-bit), cout (carry out of the top bit).
module acc_adder #(
   parameter int W = 36
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_fa
      // full-adder cell: sum and majority carry
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[W];

endmodule

// File: rtl/dot_product_acc.sv
// Sums the 2N-bit products of one vector and holds the sum for a consumer.
// Latency: result/out_valid one cycle after the closing beat; one bubble cycle after hand-off.
// Backpressure: in_ready drops while a result is held; out_ready releases it.
// Ports: clk, rst_n (async active-low), clr (sync abort), prod/in_valid/in_last/in_ready
//        (input beat handshake), result/term_count/ovf/out_valid/out_ready (result handshake).
module dot_product_acc
   import dot_product_acc_pkg::*;
#(
   parameter int N         = 16,
   parameter int G         = 4,
   parameter int MAX_TERMS = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clr,
   input  logic [2*N-1:0]                      prod,
   input  logic                                in_valid,
   input  logic                                in_last,
   output logic                                in_ready,
   output logic [acc_width(N, G)-1:0]          result,
   output logic [count_width(MAX_TERMS)-1:0]   term_count,
   output logic                                ovf,
   output logic                                out_valid,
   input  logic                                out_ready
);

   localparam int ACC_W = acc_width(N, G);
   localparam int CNT_W = count_width(MAX_TERMS);

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               sticky;

   logic [ACC_W-1:0]   sum;
   logic               carry;
   logic [CNT_W-1:0]   cnt_inc;
   logic               closing;

   acc_adder #(
      .W (ACC_W)
   ) u_acc_adder (
      .a    (acc),
      .b    (ACC_W'(prod)),
      .sum  (sum),
      .cout (carry)
   );

   assign cnt_inc   = cnt + CNT_W'(1);
   // The vector closes on in_last or when this beat would be the last allowed term.
   assign closing   = in_last || (cnt == CNT_W'(MAX_TERMS - 1));

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ACCUM;
         acc        <= '0;
         cnt        <= '0;
         sticky     <= 1'b0;
         result     <= '0;
         term_count <= '0;
         ovf        <= 1'b0;
      end else if (clr) begin
         // Abort wins over any beat or hand-off; held outputs go stale, not cleared.
         state  <= ACCUM;
         acc    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  if (closing) begin
                     result     <= sum;
                     term_count <= cnt_inc;
                     ovf        <= sticky | carry;
                     acc        <= '0;
                     cnt        <= '0;
                     sticky     <= 1'b0;
                     state      <= HOLD;
                  end else begin
                     acc    <= sum;
                     cnt    <= cnt_inc;
                     sticky <= sticky | carry;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule
